// File: rtl/fetch_stage_pkg.sv
// Shared constants and state encoding for the instruction-fetch stage.
// Provides the bubble instruction, the reset PC default and the fetch FSM states.
package fetch_stage_pkg;

    // addi x0,x0,0 -- placed in IF/ID whenever the stage inserts a bubble
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

    typedef enum logic {
        FETCH_RUN    = 1'b0,
        FETCH_HALTED = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: async reset, load on en, synchronous flush to a bubble.
// Ports: clk, rst, en, flush, d_inst/d_pc/d_pc_plus4 in; q_inst/q_pc/q_pc_plus4/q_valid out.
module if_id_reg
    import fetch_stage_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            flush,
    input  logic [31:0]     d_inst,
    input  logic [XLEN-1:0] d_pc,
    input  logic [XLEN-1:0] d_pc_plus4,
    output logic [31:0]     q_inst,
    output logic [XLEN-1:0] q_pc,
    output logic [XLEN-1:0] q_pc_plus4,
    output logic            q_valid
);

    logic [31:0]     inst_q,     inst_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] pc_plus4_q, pc_plus4_d;
    logic            valid_q,    valid_d;

    // Flush wins over enable so a redirect kills the wrong-path
    // instruction even when decode is stalling.
    // A bubble only rewrites inst/valid; the PC fields keep stale values.
    always_comb begin
        inst_d     = inst_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (flush) begin
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else if (en) begin
            inst_d     = d_inst;
            pc_d       = d_pc;
            pc_plus4_d = d_pc_plus4;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inst_q     <= NOP_INST;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign q_inst     = inst_q;
    assign q_pc       = pc_q;
    assign q_pc_plus4 = pc_plus4_q;
    assign q_valid    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, next-PC selection, halt FSM, IF/ID capture.
// Ports: clk, rst, imem_addr/imem_data, stall, redirect_valid/target, halt_req,
//        ifid_inst/pc/pc_plus4/valid, halted, misaligned_redir.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int            XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0]   NOP_INST = NOP_INST_DEF
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt_req,
    output logic [31:0]     ifid_inst,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic            ifid_valid,
    output logic            halted,
    output logic            misaligned_redir
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q,    pc_d;
    logic            mis_q,   mis_d;
    logic [XLEN-1:0] pc_plus4;
    logic            ifid_en;
    logic            ifid_flush;

    // Wraps modulo 2^XLEN by construction
    assign pc_plus4 = pc_q + XLEN'(4);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mis_d      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        unique case (state_q)
            FETCH_RUN: begin
                if (redirect_valid) begin
                    pc_d       = {redirect_target[XLEN-1:2], 2'b00};
                    mis_d      = |redirect_target[1:0];
                    ifid_flush = 1'b1;
                end else if (halt_req && ifid_valid) begin
                    state_d    = FETCH_HALTED;
                    ifid_flush = 1'b1;
                end else if (!stall) begin
                    pc_d    = pc_plus4;
                    ifid_en = 1'b1;
                end
            end
            FETCH_HALTED: begin
                // Keep IF/ID pinned to a bubble until reset
                ifid_flush = 1'b1;
            end
            default: begin
                state_d = FETCH_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH_RUN;
            pc_q    <= RESET_PC;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
        end
    end

    if_id_reg #(
        .XLEN     (XLEN),
        .NOP_INST (NOP_INST)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .en         (ifid_en),
        .flush      (ifid_flush),
        .d_inst     (imem_data),
        .d_pc       (pc_q),
        .d_pc_plus4 (pc_plus4),
        .q_inst     (ifid_inst),
        .q_pc       (ifid_pc),
        .q_pc_plus4 (ifid_pc_plus4),
        .q_valid    (ifid_valid)
    );

    assign imem_addr        = pc_q;
    assign halted           = (state_q == FETCH_HALTED);
    assign misaligned_redir = mis_q;

endmodule
